// File: rtl/sd_port_arbiter.sv
// Two-master arbiter for the single SDRAM controller port. M1 (video/DMA) has priority;
// a consecutive-grant limit keeps M0 (CPU) from starving. Whole bursts are routed before re-arbitration.
module sd_port_arbiter #(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0 (CPU)
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [3:0]  m0_req_len,
  input  logic [31:0] m0_req_addr,
  input  logic        m0_req_we,
  input  logic [31:0] m0_dout,
  input  logic [3:0]  m0_dout_mask,
  input  logic        m0_dout_valid,
  output logic        m0_dout_ready,
  output logic [31:0] m0_din,
  output logic        m0_din_valid,
  input  logic        m0_din_ready,
  // master 1 (video/DMA)
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [3:0]  m1_req_len,
  input  logic [31:0] m1_req_addr,
  input  logic        m1_req_we,
  input  logic [31:0] m1_dout,
  input  logic [3:0]  m1_dout_mask,
  input  logic        m1_dout_valid,
  output logic        m1_dout_ready,
  output logic [31:0] m1_din,
  output logic        m1_din_valid,
  input  logic        m1_din_ready,
  // SDRAM controller side
  output logic        s_req_valid,
  input  logic        s_req_ready,
  output logic [3:0]  s_req_len,
  output logic [31:0] s_req_addr,
  output logic        s_req_we,
  output logic [31:0] s_dout,
  output logic [3:0]  s_dout_mask,
  output logic        s_dout_valid,
  input  logic        s_dout_ready,
  input  logic [31:0] s_din,
  input  logic        s_din_valid,
  output logic        s_din_ready,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  localparam logic [3:0] MaxConsec = 4'(MAX_CONSEC);

  logic [1:0] state, state_next;
  logic       gnt, gnt_next;          // 1 = M1 granted
  logic [4:0] beat_cnt, beat_cnt_next;
  logic [3:0] consec_cnt, consec_cnt_next;
  logic       pick_m1;

  // Granted master's request/write signals
  logic        sel_req_valid;
  logic [3:0]  sel_req_len;
  logic [31:0] sel_req_addr;
  logic        sel_req_we;
  logic [31:0] sel_dout;
  logic [3:0]  sel_dout_mask;
  logic        sel_dout_valid;
  logic        sel_din_ready;

  always_comb begin
    sel_req_valid  = gnt ? m1_req_valid  : m0_req_valid;
    sel_req_len    = gnt ? m1_req_len    : m0_req_len;
    sel_req_addr   = gnt ? m1_req_addr   : m0_req_addr;
    sel_req_we     = gnt ? m1_req_we     : m0_req_we;
    sel_dout       = gnt ? m1_dout       : m0_dout;
    sel_dout_mask  = gnt ? m1_dout_mask  : m0_dout_mask;
    sel_dout_valid = gnt ? m1_dout_valid : m0_dout_valid;
    sel_din_ready  = gnt ? m1_din_ready  : m0_din_ready;
  end

  always_comb begin
    state_next      = state;
    gnt_next        = gnt;
    beat_cnt_next   = beat_cnt;
    consec_cnt_next = consec_cnt;
    pick_m1         = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          pick_m1  = m1_req_valid && !(m0_req_valid && (consec_cnt == MaxConsec));
          gnt_next = pick_m1;
          if (pick_m1 && m0_req_valid) begin
            consec_cnt_next = (consec_cnt == 4'hF) ? consec_cnt : consec_cnt + 4'd1;
          end else begin
            consec_cnt_next = 4'd0;
          end
          state_next = REQ;
        end
      end
      REQ: begin
        // A request withdrawn before the handshake releases the port.
        if (!sel_req_valid) begin
          state_next = IDLE;
        end else if (s_req_ready) begin
          beat_cnt_next = (sel_req_len == 4'd0) ? 5'd16 : {1'b0, sel_req_len};
          state_next    = sel_req_we ? WDATA : RDATA;
        end
      end
      WDATA: begin
        if (sel_dout_valid && s_dout_ready) begin
          beat_cnt_next = beat_cnt - 5'd1;
          if (beat_cnt == 5'd1) state_next = IDLE;
        end
      end
      RDATA: begin
        if (s_din_valid && sel_din_ready) begin
          beat_cnt_next = beat_cnt - 5'd1;
          if (beat_cnt == 5'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      beat_cnt   <= 5'd0;
      consec_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      gnt        <= gnt_next;
      beat_cnt   <= beat_cnt_next;
      consec_cnt <= consec_cnt_next;
    end
  end

  assign m0_din = s_din;
  assign m1_din = s_din;
  assign busy   = (state != IDLE);

  always_comb begin
    s_req_valid   = 1'b0;
    s_req_len     = 4'd0;
    s_req_addr    = 32'd0;
    s_req_we      = 1'b0;
    s_dout        = 32'd0;
    s_dout_mask   = 4'd0;
    s_dout_valid  = 1'b0;
    s_din_ready   = 1'b0;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_dout_ready = 1'b0;
    m1_dout_ready = 1'b0;
    m0_din_valid  = 1'b0;
    m1_din_valid  = 1'b0;
    case (state)
      REQ: begin
        s_req_valid  = sel_req_valid;
        s_req_len    = sel_req_len;
        s_req_addr   = sel_req_addr;
        s_req_we     = sel_req_we;
        m0_req_ready = !gnt && s_req_ready;
        m1_req_ready = gnt && s_req_ready;
      end
      WDATA: begin
        s_dout        = sel_dout;
        s_dout_mask   = sel_dout_mask;
        s_dout_valid  = sel_dout_valid;
        m0_dout_ready = !gnt && s_dout_ready;
        m1_dout_ready = gnt && s_dout_ready;
      end
      RDATA: begin
        s_din_ready  = sel_din_ready;
        m0_din_valid = !gnt && s_din_valid;
        m1_din_valid = gnt && s_din_valid;
      end
      default: ;
    endcase
  end

endmodule
